// File: rtl/q_step_ctrl_if.sv
// Q-table read port and Q-update handshake between the step controller and its datapath.
interface q_step_ctrl_if;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        upd_req;
  logic [5:0]  upd_state;
  logic [1:0]  upd_action;
  logic [3:0]  upd_reward;
  logic [31:0] upd_max_q;
  logic        upd_ack;

  modport master (
    output rd_en, rd_addr, upd_req, upd_state, upd_action, upd_reward, upd_max_q,
    input  rd_data, upd_ack
  );

  modport slave (
    input  rd_en, rd_addr, upd_req, upd_state, upd_action, upd_reward, upd_max_q,
    output rd_data, upd_ack
  );
endinterface

// File: rtl/q_step_ctrl.sv
// Q-learning episode sequencer: greedy action scan, grid move, next-row max scan, update handshake.
module q_step_ctrl #(
  parameter int unsigned N_ROWS      = 6,
  parameter int unsigned N_COLS      = 6,
  parameter int unsigned START_STATE = 0,
  parameter int unsigned GOAL_STATE  = 35,
  parameter int unsigned MAX_STEPS   = 64,
  parameter int unsigned GOAL_REWARD = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  q_step_ctrl_if.master       q,
  output logic                busy,
  output logic                done,
  output logic                goal_hit,
  output logic [7:0]          step_cnt,
  output logic [5:0]          cur_state
);

  typedef enum logic [2:0] {IDLE, SCAN_A, MOVE, SCAN_M, UPDATE, NEXT, DONE} state_t;

  localparam logic [5:0] START6 = 6'(START_STATE);
  localparam logic [5:0] GOAL6  = 6'(GOAL_STATE);

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] best_q, new_best;
  logic [1:0]  best_idx, new_idx, action;
  logic [5:0]  next_state, move_state, scan_row;
  logic [3:0]  reward;
  logic        take, last_step;
  int unsigned cs, row, col;

  // cnt==1 carries data for index 0, which always seeds the running max; strict > keeps ties low.
  always_comb begin
    take     = (cnt == 3'd1) || (q.rd_data > best_q);
    new_best = take ? q.rd_data : best_q;
    new_idx  = take ? 2'(cnt - 3'd1) : best_idx;
    scan_row = (state == SCAN_A) ? cur_state : next_state;
  end

  always_comb begin
    cs         = 32'(cur_state);
    row        = cs / N_COLS;
    col        = cs % N_COLS;
    move_state = cur_state;
    case (action)
      2'd0:    if (row > 0)          move_state = 6'(cs - N_COLS);
      2'd1:    if (col < N_COLS - 1) move_state = 6'(cs + 1);
      2'd2:    if (row < N_ROWS - 1) move_state = 6'(cs + N_COLS);
      default: if (col > 0)          move_state = 6'(cs - 1);
    endcase
  end

  assign last_step = (9'(step_cnt) + 9'd1) == 9'(MAX_STEPS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      best_q       <= '0;
      best_idx     <= '0;
      action       <= '0;
      next_state   <= START6;
      reward       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      goal_hit     <= 1'b0;
      step_cnt     <= '0;
      cur_state    <= START6;
      q.rd_en      <= 1'b0;
      q.rd_addr    <= '0;
      q.upd_req    <= 1'b0;
      q.upd_state  <= '0;
      q.upd_action <= '0;
      q.upd_reward <= '0;
      q.upd_max_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            cur_state <= START6;
            step_cnt  <= '0;
            if (START_STATE == GOAL_STATE) begin
              goal_hit <= 1'b1;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              goal_hit  <= 1'b0;
              q.rd_en   <= 1'b1;
              q.rd_addr <= {START6, 2'b00};
              cnt       <= '0;
              state     <= SCAN_A;
            end
          end
        end
        SCAN_A, SCAN_M: begin
          // Reads issue on cnt 0..3; the registered read data lags by one, so cnt 4 only drains.
          cnt <= cnt + 3'd1;
          if (cnt < 3'd3) q.rd_addr <= {scan_row, cnt[1:0] + 2'd1};
          else            q.rd_en   <= 1'b0;
          if (cnt != 3'd0) begin
            best_q   <= new_best;
            best_idx <= new_idx;
          end
          if (cnt == 3'd4) begin
            if (state == SCAN_A) begin
              action <= new_idx;
              state  <= MOVE;
            end else begin
              q.upd_req    <= 1'b1;
              q.upd_state  <= cur_state;
              q.upd_action <= action;
              q.upd_reward <= reward;
              q.upd_max_q  <= new_best;
              state        <= UPDATE;
            end
          end
        end
        MOVE: begin
          next_state <= move_state;
          reward     <= (move_state == GOAL6) ? 4'(GOAL_REWARD) : 4'd0;
          q.rd_en    <= 1'b1;
          q.rd_addr  <= {move_state, 2'b00};
          cnt        <= '0;
          state      <= SCAN_M;
        end
        UPDATE: begin
          if (q.upd_ack) begin
            q.upd_req <= 1'b0;
            state     <= NEXT;
          end
        end
        NEXT: begin
          cur_state <= next_state;
          step_cnt  <= step_cnt + 8'd1;
          if (next_state == GOAL6) begin
            goal_hit <= 1'b1;
            done     <= 1'b1;
            state    <= DONE;
          end else if (last_step) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            q.rd_en   <= 1'b1;
            q.rd_addr <= {next_state, 2'b00};
            cnt       <= '0;
            state     <= SCAN_A;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q_step_ctrl.sv
// Bench for q_step_ctrl: episode table, random Q-tables vs a grid-walk model, and timing corner sequences.
module tb_q_step_ctrl;
  localparam int NR = 6, NC = 6, GOAL = 35, MAXS = 64;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, start2 = 1'b0;
  logic busy, done, goal_hit, busy2, done2, goal_hit2;
  logic [7:0] step_cnt, step_cnt2;
  logic [5:0] cur_state, cur_state2;

  q_step_ctrl_if ifc();
  q_step_ctrl_if if2();

  q_step_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .q(ifc),
    .busy(busy), .done(done), .goal_hit(goal_hit), .step_cnt(step_cnt), .cur_state(cur_state)
  );

  q_step_ctrl #(.START_STATE(35), .GOAL_STATE(35)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .q(if2),
    .busy(busy2), .done(done2), .goal_hit(goal_hit2), .step_cnt(step_cnt2), .cur_state(cur_state2)
  );

  always #5 clk = ~clk;

  logic [31:0] q_mem [256];
  int ack_delay = 0, wait_cnt = 0, bad2 = 0;
  bit ack_noise = 1'b0;
  int checks = 0, errors = 0;

  typedef struct {int st; int act; int rew; logic [31:0] mq;} upd_t;
  upd_t upd_q[$], exp_upd[$];
  int rd_q[$], exp_rd[$];

  typedef struct {int pat; int delay; bit noise; int exp_steps; bit exp_goal; int exp_state;} vec_t;
  vec_t vecs[4];

  always @(posedge clk) ifc.rd_data <= ifc.rd_en ? q_mem[ifc.rd_addr] : '0;

  always @(posedge clk) begin
    #1;
    if (ifc.upd_req) begin
      ifc.upd_ack = (wait_cnt >= ack_delay);
      wait_cnt++;
    end else begin
      wait_cnt = 0;
      ifc.upd_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (ifc.rd_en) rd_q.push_back(int'(ifc.rd_addr));
    if (ifc.upd_req && ifc.upd_ack)
      upd_q.push_back('{int'(ifc.upd_state), int'(ifc.upd_action), int'(ifc.upd_reward), ifc.upd_max_q});
    if (if2.rd_en || if2.upd_req) bad2++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int best_act(int s);
    int b;
    b = 0;
    for (int a = 1; a < 4; a++) if (q_mem[s*4+a] > q_mem[s*4+b]) b = a;
    return b;
  endfunction

  function automatic logic [31:0] row_max(int s);
    logic [31:0] m;
    m = '0;
    for (int a = 0; a < 4; a++) if (q_mem[s*4+a] > m) m = q_mem[s*4+a];
    return m;
  endfunction

  function automatic int step_to(int s, int a);
    int dr[4], dc[4], r, c;
    dr = '{-1, 0, 1, 0};
    dc = '{0, 1, 0, -1};
    r = s / NC + dr[a];
    c = s % NC + dc[a];
    if (r < 0 || r >= NR || c < 0 || c >= NC) return s;
    return r * NC + c;
  endfunction

  task automatic fill_q(input int pat);
    for (int s = 0; s < 64; s++)
      for (int a = 0; a < 4; a++) begin
        case (pat)
          1:       q_mem[s*4+a] = ((s < 30 && a == 2) || (s >= 30 && a == 1)) ? 32'd1 : 32'd0;
          2:       q_mem[s*4+a] = (a == 1) ? 32'd5 : 32'd0;
          3:       q_mem[s*4+a] = (a == 2) ? 32'd3 : 32'd0;
          4:       q_mem[s*4+a] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
          default: q_mem[s*4+a] = 32'd0;
        endcase
      end
  endtask

  task automatic model_episode(output int m_steps, output bit m_goal, output int m_state);
    int s, a, ns;
    bit stop;
    exp_upd.delete();
    exp_rd.delete();
    s = 0; m_steps = 0; m_goal = 1'b0; stop = 1'b0;
    for (int k = 0; k < MAXS && !stop; k++) begin
      a  = best_act(s);
      ns = step_to(s, a);
      for (int i = 0; i < 4; i++) exp_rd.push_back(s*4 + i);
      for (int i = 0; i < 4; i++) exp_rd.push_back(ns*4 + i);
      exp_upd.push_back('{s, a, (ns == GOAL) ? 10 : 0, row_max(ns)});
      s = ns;
      m_steps++;
      if (ns == GOAL) begin m_goal = 1'b1; stop = 1'b1; end
    end
    m_state = s;
  endtask

  task automatic run_episode(input int d, input bit noise, output int o_steps, output int o_goal, output int o_state);
    int cyc, m_steps, m_state, nbad, n;
    bit seen, m_goal;
    ack_delay = d;
    ack_noise = noise;
    @(negedge clk);
    rd_q.delete();
    upd_q.delete();
    start = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 6000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    o_steps = int'(step_cnt); o_goal = int'(goal_hit); o_state = int'(cur_state);
    model_episode(m_steps, m_goal, m_state);
    chk("step_cnt", 64'(step_cnt), 64'(m_steps));
    chk("goal_hit", 64'(goal_hit), 64'(m_goal));
    chk("cur_state", 64'(cur_state), 64'(m_state));
    chk("episode_cycles", 64'(cyc), 64'(m_steps * (13 + d) + 1));
    chk("busy_in_done", 64'(busy), 64'd1);
    chk("upd_count", 64'(upd_q.size()), 64'(exp_upd.size()));
    nbad = 0;
    n = (upd_q.size() < exp_upd.size()) ? upd_q.size() : exp_upd.size();
    for (int i = 0; i < n; i++)
      if (upd_q[i] != exp_upd[i]) begin
        nbad++;
        if (nbad == 1)
          $display("FAIL upd_payload[%0d]: got s=%0d a=%0d r=%0d mq=%0d expected s=%0d a=%0d r=%0d mq=%0d", i,
                   upd_q[i].st, upd_q[i].act, upd_q[i].rew, upd_q[i].mq,
                   exp_upd[i].st, exp_upd[i].act, exp_upd[i].rew, exp_upd[i].mq);
      end
    chk("upd_payload_bad", 64'(nbad), 64'd0);
    chk("read_count", 64'(rd_q.size()), 64'(exp_rd.size()));
    nbad = 0;
    n = (rd_q.size() < exp_rd.size()) ? rd_q.size() : exp_rd.size();
    for (int i = 0; i < n; i++) if (rd_q[i] != exp_rd[i]) nbad++;
    chk("read_addr_bad", 64'(nbad), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
    ack_noise = 1'b0;
  endtask

  task automatic wait_cond(input int which, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      case (which)
        0:       ok = ifc.upd_req;
        1:       ok = done;
        default: ok = ifc.rd_en && (ifc.rd_addr == 8'd48);
      endcase
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_goal"}, 64'(goal_hit), 64'd0);
    chk({tag, "_step"}, 64'(step_cnt), 64'd0);
    chk({tag, "_state"}, 64'(cur_state), 64'd0);
    chk({tag, "_rd_en"}, 64'(ifc.rd_en), 64'd0);
    chk({tag, "_rd_addr"}, 64'(ifc.rd_addr), 64'd0);
    chk({tag, "_upd_req"}, 64'(ifc.upd_req), 64'd0);
    chk({tag, "_payload"}, {ifc.upd_state, ifc.upd_action, ifc.upd_reward, ifc.upd_max_q}, 64'd0);
  endtask

  initial begin
    int st, gh, cs;
    bit ok;
    int n, nbad;
    logic [43:0] p0;

    if2.rd_data = '0;
    if2.upd_ack = 1'b0;
    vecs[0] = '{0, 0, 1'b0, 64, 1'b0, 0};
    vecs[1] = '{1, 0, 1'b1, 10, 1'b1, 35};
    vecs[2] = '{2, 1, 1'b0, 64, 1'b0, 5};
    vecs[3] = '{3, 2, 1'b1, 64, 1'b0, 30};

    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 4; v++) begin
      fill_q(vecs[v].pat);
      run_episode(vecs[v].delay, vecs[v].noise, st, gh, cs);
      chk("tbl_steps", 64'(st), 64'(vecs[v].exp_steps));
      chk("tbl_goal", 64'(gh), 64'(vecs[v].exp_goal));
      chk("tbl_state", 64'(cs), 64'(vecs[v].exp_state));
    end

    for (int r = 0; r < 6; r++) begin
      fill_q(4);
      run_episode($urandom_range(0, 2), 1'($urandom_range(0, 1)), st, gh, cs);
    end

    // First scan timing and tie-break to lowest index.
    fill_q(0);
    q_mem[0] = 32'd7; q_mem[1] = 32'd9; q_mem[2] = 32'd9; q_mem[3] = 32'd3;
    ack_delay = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("scan_busy", 64'(busy), 64'd1);
    chk("scan_rd_en0", 64'(ifc.rd_en), 64'd1);
    chk("scan_addr0", 64'(ifc.rd_addr), 64'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("scan_rd_en", 64'(ifc.rd_en), 64'd1);
      chk("scan_addr", 64'(ifc.rd_addr), 64'(k));
    end
    @(negedge clk);
    chk("scan_rd_en_off", 64'(ifc.rd_en), 64'd0);
    wait_cond(0, 50, ok);
    chk("tie_upd_seen", 64'(ok), 64'd1);
    chk("tie_action", 64'(ifc.upd_action), 64'd1);
    chk("tie_state", 64'(ifc.upd_state), 64'd0);
    wait_cond(1, 2000, ok);
    chk("tie_done_seen", 64'(ok), 64'd1);
    @(negedge clk);

    // Held ack: payload stable, start ignored, advance right after ack.
    fill_q(0);
    ack_delay = 3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cond(0, 50, ok);
    chk("hold_upd_seen", 64'(ok), 64'd1);
    p0 = {ifc.upd_state, ifc.upd_action, ifc.upd_reward, ifc.upd_max_q};
    n = 1; nbad = 0;
    start = 1'b1;
    while (ifc.upd_req && n < 20) begin
      @(negedge clk);
      if (ifc.upd_req) begin
        n++;
        if ({ifc.upd_state, ifc.upd_action, ifc.upd_reward, ifc.upd_max_q} != p0) nbad++;
      end
    end
    start = 1'b0;
    chk("hold_req_cycles", 64'(n), 64'd4);
    chk("hold_payload_bad", 64'(nbad), 64'd0);
    chk("hold_next_rd_en", 64'(ifc.rd_en), 64'd0);
    @(negedge clk);
    chk("hold_rescan_rd_en", 64'(ifc.rd_en), 64'd1);
    chk("hold_rescan_addr", 64'(ifc.rd_addr), 64'd0);
    chk("hold_step_cnt", 64'(step_cnt), 64'd1);
    do_reset();
    ack_delay = 0;

    // Reset in the middle of step 2's next-state scan.
    fill_q(3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cond(2, 100, ok);
    chk("midrst_reached", 64'(ok), 64'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    nbad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ifc.rd_en || ifc.upd_req || busy) nbad++;
    end
    chk("midrst_quiet", 64'(nbad), 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_rd_en", 64'(ifc.rd_en), 64'd1);
    chk("restart_addr", 64'(ifc.rd_addr), 64'd0);
    chk("restart_step", 64'(step_cnt), 64'd0);
    chk("restart_state", 64'(cur_state), 64'd0);
    do_reset();

    // START_STATE == GOAL_STATE instance.
    bad2 = 0;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("sg_done", 64'(done2), 64'd1);
    chk("sg_goal", 64'(goal_hit2), 64'd1);
    chk("sg_step", 64'(step_cnt2), 64'd0);
    chk("sg_state", 64'(cur_state2), 64'd35);
    chk("sg_busy", 64'(busy2), 64'd1);
    @(negedge clk);
    chk("sg_done_off", 64'(done2), 64'd0);
    chk("sg_busy_off", 64'(busy2), 64'd0);
    chk("sg_goal_hold", 64'(goal_hit2), 64'd1);
    chk("sg_no_traffic", 64'(bad2), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
